row_compressor: RTL and testbench
=================================

// Module: row_compressor
// PURPOSE
//   Run-length encoder: the transmit-side counterpart of the row Decompressor in IOModule.
//   Takes one raw binary row and produces the packed run-length word that the Decompressor consumes.
//   Sits in the IO path between the host/row buffer and the external link or memory.
//   Scans one bit per clock; multi-cycle, with a start/busy/done handshake.
// PARAMETERS
//   sectionSize  4   bits per run-length field; max run per field = 2**sectionSize-1
//   rowSize      16  raw row width = compressed word width; NUM_SECTIONS = rowSize/sectionSize
// PORTS
//   clk               in   1        single clock; all logic on posedge
//   rst               in   1        synchronous, active-low reset
//   start             in   1        1-cycle request; rawData sampled on the same edge
//   rawData           in   rowSize  row to compress
//   compressedData    out  rowSize  packed run lengths; section k = bits [k*S+S-1 : k*S]
//   busy              out  1        high while encoding
//   done              out  1        level; high from completion until next accepted start or reset
//   overflow          out  1        encoding needed more than NUM_SECTIONS fields; valid with done
// BEHAVIOUR
//   Encoding (must round-trip through Decompressor):
//     - Section 0 holds the first run and always counts 0-digits. Runs alternate 0,1,0,... upward.
//     - Runs start from rawData bit 0. If bit 0 = 1, section 0 = 0.
//     - A run longer than MAX = 2**S-1 is split: emit MAX, then a 0-length field for the opposite digit, then continue the same run.
//     - A trailing run of 0s is never emitted. An all-zero row gives compressedData = 0.
//     - Unused upper sections are 0.
//   FSM:
//     - IDLE:  start=1 -> latch rawData, clear compressedData/overflow/done, set curDigit=0, runLen=0, bitIdx=0, secIdx=0; -> SCAN.
//     - SCAN:  one bit per cycle at bitIdx.
//         - bit==curDigit and runLen<MAX: runLen++.
//         - bit==curDigit and runLen==MAX: write MAX at secIdx; secIdx+=2 (the skipped field stays 0); runLen=1.
//         - bit!=curDigit: write runLen at secIdx; secIdx++; curDigit flips; runLen=1.
//         - After bitIdx==rowSize-1 -> FLUSH.
//     - FLUSH: if curDigit==1, write runLen at secIdx. Then busy=0, done=1; -> IDLE.
//   Latency: done rises rowSize+2 edges after the edge sampling start. With defaults: start at edge 0, done high after edge 18.
//   Overflow:
//     - Any write with field index >= NUM_SECTIONS sets overflow and is dropped.
//     - A split whose second, 0-length field lands at index >= NUM_SECTIONS also sets overflow.
//     - Encoding continues; compressedData holds the first NUM_SECTIONS fields.
//   Handshake:
//     - start while busy is ignored.
//     - start in the same cycle done is high is accepted; done drops on the next edge.
//   Width rules: runLen is S+1 bits wide; secIdx is wide enough to hold NUM_SECTIONS+1 without wrap.
//   Reset (rst=0 at posedge, even mid-scan):
//     - State -> IDLE.
//     - compressedData=0, busy=0, done=0, overflow=0, and all counters cleared.
//   compressedData is stable and only changes while busy or on reset.
// CONFIGURATION
//   COMPRESS_SECTION_COUNT_EN
//     - Defined: adds output sectionCount [$clog2(NUM_SECTIONS+1)-1:0].
//     - sectionCount = number of fields emitted, saturating at NUM_SECTIONS. It includes split 0-fields and is valid with done.
//     - sectionCount resets to 0.
//   Undefined: port and counter are absent; behaviour is otherwise identical.
// TESTING (S=4, rowSize=16)
//   - rawData=16'h0000 -> compressedData=16'h0000, overflow=0, done 18 edges after start.
//   - rawData=16'h00F0 -> 16'h0044, overflow=0 (trailing zeros dropped); sectionCount=2.
//   - rawData=16'hFFFF -> 16'h10F0 (0,15,split 0,1), overflow=0; sectionCount=4.
//   - rawData=16'h8001 -> 16'h1E10, overflow=0.
//   - rawData=16'h5555 -> 16'h1110, overflow=1; sectionCount=4.
//   - start again while busy -> ignored, result unchanged.
//   - rst=0 at scan bit 7 -> next cycle busy=0, done=0, compressedData=0.
//   - Round-trip: feed every output with overflow=0 into Decompressor -> reproduces rawData. Cover 2000 random rows.

Source files
------------

// File: rtl/row_compressor.sv
// ============================================================================
//  Module   : row_compressor
//  Purpose  : Bit-serial run-length encoder producing the packed row word
//             that the row Decompressor consumes. Optional sectionCount
//             output enabled by defining COMPRESS_SECTION_COUNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module row_compressor #(
   parameter int sectionSize = 4,
   parameter int rowSize     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [rowSize-1:0] rawData,
   output logic [rowSize-1:0] compressedData,
   output logic               busy,
   output logic               done,
   output logic               overflow
`ifdef COMPRESS_SECTION_COUNT_EN
   ,
   output logic [$clog2(rowSize/sectionSize+1)-1:0] sectionCount
`endif
);

   localparam int NUM_SECTIONS = rowSize / sectionSize;
   localparam int SEC_W        = $clog2(NUM_SECTIONS + 2);
   localparam int CNT_W        = $clog2(NUM_SECTIONS + 1);
   localparam int BIT_W        = $clog2(rowSize);
   localparam logic [sectionSize:0] MAX_RUN  = {1'b0, {sectionSize{1'b1}}};
   localparam logic [sectionSize:0] RUN_ONE  = (sectionSize+1)'(1);
   localparam logic [SEC_W-1:0]     NS_IDX   = SEC_W'(NUM_SECTIONS);
   localparam logic [SEC_W-1:0]     NS_LAST  = SEC_W'(NUM_SECTIONS - 1);
   localparam logic [SEC_W-1:0]     STEP_ONE = SEC_W'(1);
   localparam logic [SEC_W-1:0]     STEP_TWO = SEC_W'(2);
   localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(rowSize - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_FLUSH = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   state_t                 state_q;
   logic [rowSize-1:0]     raw_q;
   logic [rowSize-1:0]     comp_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   ovf_q;
   logic                   cur_q;
   logic [sectionSize:0]   run_q;
   logic [BIT_W-1:0]       bit_q;
   logic [SEC_W-1:0]       sec_q;
`ifdef COMPRESS_SECTION_COUNT_EN
   logic [CNT_W-1:0]       cnt_q;
`endif

   // Out-of-range indices leave the word untouched; the caller flags overflow.
   function automatic logic [rowSize-1:0] put_field(input logic [rowSize-1:0]     word,
                                                    input logic [SEC_W-1:0]       idx,
                                                    input logic [sectionSize-1:0] val);
      logic [rowSize-1:0] w;
      w = word;
      for (int k = 0; k < NUM_SECTIONS; k++) begin
         if (idx == SEC_W'(k)) w[k*sectionSize +: sectionSize] = val;
      end
      return w;
   endfunction

   function automatic logic [SEC_W-1:0] sec_adv(input logic [SEC_W-1:0] idx,
                                                input logic [SEC_W-1:0] step);
      logic [SEC_W:0] s;
      s = {1'b0, idx} + {1'b0, step};
      return (s > {1'b0, NS_IDX}) ? NS_IDX : s[SEC_W-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         raw_q   <= '0;
         comp_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cur_q   <= 1'b0;
         run_q   <= '0;
         bit_q   <= '0;
         sec_q   <= '0;
`ifdef COMPRESS_SECTION_COUNT_EN
         cnt_q   <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  raw_q   <= rawData;
                  comp_q  <= '0;
                  ovf_q   <= 1'b0;
                  done_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  cur_q   <= 1'b0;
                  run_q   <= '0;
                  bit_q   <= '0;
                  sec_q   <= '0;
`ifdef COMPRESS_SECTION_COUNT_EN
                  cnt_q   <= '0;
`endif
                  state_q <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (raw_q[bit_q] == cur_q) begin
                  if (run_q == MAX_RUN) begin
                     // A zero run with no 1 ahead is trailing and is never emitted.
                     if (cur_q || (|(raw_q >> bit_q))) begin
                        comp_q <= put_field(comp_q, sec_q, MAX_RUN[sectionSize-1:0]);
                        if (sec_q >= NS_LAST) ovf_q <= 1'b1;
                        sec_q  <= sec_adv(sec_q, STEP_TWO);
                     end
                     run_q <= RUN_ONE;
                  end else begin
                     run_q <= run_q + RUN_ONE;
                  end
               end else begin
                  comp_q <= put_field(comp_q, sec_q, run_q[sectionSize-1:0]);
                  if (sec_q >= NS_IDX) ovf_q <= 1'b1;
                  sec_q  <= sec_adv(sec_q, STEP_ONE);
                  cur_q  <= ~cur_q;
                  run_q  <= RUN_ONE;
               end
               if (bit_q == BIT_LAST) state_q <= S_FLUSH;
               else                   bit_q   <= bit_q + BIT_W'(1);
            end
            S_FLUSH: begin
               if (cur_q) begin
                  comp_q <= put_field(comp_q, sec_q, run_q[sectionSize-1:0]);
                  if (sec_q >= NS_IDX) ovf_q <= 1'b1;
                  sec_q  <= sec_adv(sec_q, STEP_ONE);
               end
               state_q <= S_FIN;
            end
            S_FIN: begin
`ifdef COMPRESS_SECTION_COUNT_EN
               cnt_q   <= sec_q[CNT_W-1:0];
`endif
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign compressedData = comp_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign overflow       = ovf_q;
`ifdef COMPRESS_SECTION_COUNT_EN
   assign sectionCount   = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_row_compressor.sv
// ============================================================================
//  Module   : tb_row_compressor
//  Purpose  : Directed and round-trip self-checking bench for row_compressor.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_row_compressor;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] rawData;
   logic [15:0] compressedData;
   logic        busy;
   logic        done;
   logic        overflow;
`ifdef COMPRESS_SECTION_COUNT_EN
   logic [2:0]  sectionCount;
`endif

   int n_cmp;
   int n_err;

   row_compressor #(.sectionSize(4), .rowSize(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .rawData        (rawData),
      .compressedData (compressedData),
      .busy           (busy),
      .done           (done),
      .overflow       (overflow)
`ifdef COMPRESS_SECTION_COUNT_EN
      ,
      .sectionCount   (sectionCount)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference decoder: sections alternate 0-runs and 1-runs from bit 0 upward.
   function automatic logic [15:0] decomp(input logic [15:0] c);
      logic [15:0] r;
      logic [3:0]  f;
      logic        d;
      int          pos;
      r   = '0;
      d   = 1'b0;
      pos = 0;
      for (int k = 0; k < 4; k++) begin
         f = c[k*4 +: 4];
         for (int j = 0; j < int'(f); j++) begin
            if (pos < 16) r[pos] = d;
            pos++;
         end
         d = ~d;
      end
      return r;
   endfunction

   // Issues start at the next edge and counts edges until done (bounded).
   task automatic run_row(input logic [15:0] r, output int lat);
      @(negedge clk);
      start   = 1'b1;
      rawData = r;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 0;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   logic [15:0] v_raw [8];
   logic [15:0] v_exp [8];
   logic        v_ovf [8];
   logic [2:0]  v_cnt [8];

   initial begin
      int          lat;
      logic [15:0] r;

      n_cmp   = 0;
      n_err   = 0;
      rst     = 1'b0;
      start   = 1'b0;
      rawData = '0;

      v_raw = '{16'h0000, 16'h00F0, 16'hFFFF, 16'h8001, 16'h5555, 16'h8000, 16'h0001, 16'hFFFE};
      v_exp = '{16'h0000, 16'h0044, 16'h10F0, 16'h1E10, 16'h1110, 16'h001F, 16'h0010, 16'h00F1};
      v_ovf = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b0};
      v_cnt = '{3'd0,     3'd2,     3'd4,     3'd4,     3'd4,     3'd2,     3'd2,     3'd2};

      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_data", 32'(compressedData), 32'd0);
      check("reset_ovf",  32'(overflow), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_row(v_raw[i], lat);
         check($sformatf("latency_%04h", v_raw[i]), 32'(lat), 32'd18);
         check($sformatf("data_%04h", v_raw[i]), 32'(compressedData), 32'(v_exp[i]));
         check($sformatf("ovf_%04h", v_raw[i]), 32'(overflow), 32'(v_ovf[i]));
         check($sformatf("busy_low_%04h", v_raw[i]), 32'(busy), 32'd0);
`ifdef COMPRESS_SECTION_COUNT_EN
         check($sformatf("count_%04h", v_raw[i]), 32'(sectionCount), 32'(v_cnt[i]));
`endif
      end

      // done is a level and the result holds while idle
      repeat (3) @(posedge clk);
      #1;
      check("done_level", 32'(done), 32'd1);
      check("data_hold", 32'(compressedData), 32'h00F1);

      // start while done is high is accepted; done drops on that edge
      @(negedge clk);
      start   = 1'b1;
      rawData = 16'h00F0;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("restart_done_drop", 32'(done), 32'd0);
      check("restart_busy", 32'(busy), 32'd1);

      // a second start during the scan is ignored
      repeat (4) @(posedge clk);
      @(negedge clk);
      start   = 1'b1;
      rawData = 16'hFFFF;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("busy_start_done", 32'(done), 32'd1);
      check("busy_start_data", 32'(compressedData), 32'h0044);
      check("busy_start_ovf", 32'(overflow), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("busy_start_idle", 32'(busy), 32'd0);

      // reset asserted while scanning bit 7
      run_row(16'h5555, lat);
      @(negedge clk);
      start   = 1'b1;
      rawData = 16'hFFFF;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      check("midscan_busy_pre", 32'(busy), 32'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("midscan_rst_busy", 32'(busy), 32'd0);
      check("midscan_rst_done", 32'(done), 32'd0);
      check("midscan_rst_data", 32'(compressedData), 32'd0);
      check("midscan_rst_ovf", 32'(overflow), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      run_row(16'h8001, lat);
      check("post_rst_latency", 32'(lat), 32'd18);
      check("post_rst_data", 32'(compressedData), 32'h1E10);

      // round trip through the reference decoder
      for (int i = 0; i < 2000; i++) begin
         r = 16'($urandom);
         run_row(r, lat);
         if (lat >= 40) check("rt_timeout", 32'(lat), 32'd18);
         else if (!overflow) check($sformatf("roundtrip_%04h", r), 32'(decomp(compressedData)), 32'(r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
